// File: rtl/serial_equality_checker_pkg.sv
// Shared types and width helpers for the serial word comparator.
package serial_eq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  // Bit-index width; a floor of 1 keeps the vector legal for tiny words.
  function automatic int iw_of(input int width);
    return (width <= 2) ? 1 : $clog2(width);
  endfunction

  // Match-count width, sized to hold 0..width inclusive.
  function automatic int cw_of(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/serial_equality_checker_if.sv
// Serial operand stream and word-result bundle between a source and the comparator.
interface serial_equality_checker_if #(
  parameter int WIDTH = 8
) ();

  logic                                    start;
  logic                                    bit_valid;
  logic                                    a_bit;
  logic                                    b_bit;
  logic                                    busy;
  logic                                    done;
  logic                                    equal;
  logic [serial_eq_pkg::cw_of(WIDTH)-1:0]  match_count;
  logic                                    mismatch_seen;
  logic [serial_eq_pkg::iw_of(WIDTH)-1:0]  first_mismatch;

  modport master (
    output start, bit_valid, a_bit, b_bit,
    input  busy, done, equal, match_count, mismatch_seen, first_mismatch
  );

  modport slave (
    input  start, bit_valid, a_bit, b_bit,
    output busy, done, equal, match_count, mismatch_seen, first_mismatch
  );

endinterface

// File: rtl/serial_equality_checker_equiv_cell.sv
// Single-bit equivalence cell: eq is high when both inputs agree.
module equiv_cell (
  input  logic a,
  input  logic b,
  output logic eq
);

  assign eq = ~(a ^ b);

endmodule

// File: rtl/serial_equality_checker.sv
// Word-level comparator for two LSB-first serial streams, built around one
// equivalence cell evaluated per accepted bit pair.
module serial_equality_checker
  import serial_eq_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  serial_equality_checker_if.slave bus
);

  localparam int IW = iw_of(WIDTH);
  localparam int CW = cw_of(WIDTH);

  state_e          state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            run_seen_q, run_seen_d;
  logic [IW-1:0]   run_first_q, run_first_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            equal_q, equal_d;
  logic [CW-1:0]   match_count_q, match_count_d;
  logic            mismatch_seen_q, mismatch_seen_d;
  logic [IW-1:0]   first_mismatch_q, first_mismatch_d;
  logic            eq;

  equiv_cell u_equiv_cell (
    .a  (bus.a_bit),
    .b  (bus.b_bit),
    .eq (eq)
  );

  always_comb begin
    state_d          = state_q;
    idx_d            = idx_q;
    cnt_d            = cnt_q;
    run_seen_d       = run_seen_q;
    run_first_d      = run_first_q;
    equal_d          = equal_q;
    match_count_d    = match_count_q;
    mismatch_seen_d  = mismatch_seen_q;
    first_mismatch_d = first_mismatch_q;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d     = SHIFT;
          idx_d       = '0;
          cnt_d       = '0;
          run_seen_d  = 1'b0;
          run_first_d = '0;
        end
      end

      SHIFT: begin
        if (bus.bit_valid) begin
          cnt_d = cnt_q + CW'(eq);
          if (!eq && !run_seen_q) begin
            run_seen_d  = 1'b1;
            run_first_d = idx_q;
          end
          // Results are loaded from the running values including this last bit.
          if (idx_q == IW'(WIDTH - 1)) begin
            state_d          = DONE;
            equal_d          = (cnt_d == CW'(WIDTH));
            match_count_d    = cnt_d;
            mismatch_seen_d  = run_seen_d;
            first_mismatch_d = run_first_d;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
      end

      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == SHIFT);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q          <= IDLE;
      idx_q            <= '0;
      cnt_q            <= '0;
      run_seen_q       <= 1'b0;
      run_first_q      <= '0;
      busy_q           <= 1'b0;
      done_q           <= 1'b0;
      equal_q          <= 1'b0;
      match_count_q    <= '0;
      mismatch_seen_q  <= 1'b0;
      first_mismatch_q <= '0;
    end else begin
      state_q          <= state_d;
      idx_q            <= idx_d;
      cnt_q            <= cnt_d;
      run_seen_q       <= run_seen_d;
      run_first_q      <= run_first_d;
      busy_q           <= busy_d;
      done_q           <= done_d;
      equal_q          <= equal_d;
      match_count_q    <= match_count_d;
      mismatch_seen_q  <= mismatch_seen_d;
      first_mismatch_q <= first_mismatch_d;
    end
  end

  assign bus.busy           = busy_q;
  assign bus.done           = done_q;
  assign bus.equal          = equal_q;
  assign bus.match_count    = match_count_q;
  assign bus.mismatch_seen  = mismatch_seen_q;
  assign bus.first_mismatch = first_mismatch_q;

endmodule

// File: tb/tb_serial_equality_checker.sv
// Self-checking bench for serial_equality_checker: directed words, stalls,
// ignored starts, async reset and randomized words against a word-level model.
module tb_serial_equality_checker;

  localparam int WIDTH = 4;

  logic clk;
  logic rst;

  int checks   = 0;
  int failures = 0;

  int exp_equal = 0;
  int exp_count = 0;
  int exp_seen  = 0;
  int exp_first = 0;

  serial_equality_checker_if #(.WIDTH(WIDTH)) bus ();

  serial_equality_checker #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic checkResults(input string tag);
    checkOutput({tag, "_equal"}, bus.equal, exp_equal);
    checkOutput({tag, "_count"}, bus.match_count, exp_count);
    checkOutput({tag, "_seen"},  bus.mismatch_seen, exp_seen);
    checkOutput({tag, "_first"}, bus.first_mismatch, exp_first);
  endtask

  // Word-level reference: count agreeing positions, find lowest differing one.
  task automatic modelWord(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    int cnt;
    int first;
    cnt   = 0;
    first = -1;
    for (int i = 0; i < WIDTH; i++) begin
      if (a[i] == b[i]) cnt++;
      else if (first < 0) first = i;
    end
    exp_count = cnt;
    exp_equal = (cnt == WIDTH) ? 1 : 0;
    exp_seen  = (first >= 0) ? 1 : 0;
    exp_first = (first >= 0) ? first : 0;
  endtask

  // stall_mode: 0 = continuous, 1 = fixed 1,0,0,1,1,0,1 valid pattern, 2 = random stalls
  task automatic applyStimulus(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                               input int stall_mode, input bit poke_start);
    int accepted;
    int cyc;
    logic v;
    logic [6:0] valid_pat;
    valid_pat = 7'b1011001;
    accepted  = 0;
    cyc       = 0;

    bus.start     = 1'b1;
    bus.bit_valid = 1'($urandom_range(0, 1));
    bus.a_bit     = 1'($urandom_range(0, 1));
    bus.b_bit     = 1'($urandom_range(0, 1));
    stepCycle();
    bus.start = 1'b0;
    checkOutput("busy_after_start", bus.busy, 1);
    checkOutput("done_after_start", bus.done, 0);

    while (accepted < WIDTH) begin
      if (stall_mode == 1)      v = (cyc < 7) ? valid_pat[cyc] : 1'b1;
      else if (stall_mode == 2) v = ($urandom_range(0, 3) != 0);
      else                      v = 1'b1;
      cyc++;
      bus.bit_valid = v;
      bus.start     = poke_start && ($urandom_range(0, 2) == 0);
      if (v) begin
        bus.a_bit = a[accepted];
        bus.b_bit = b[accepted];
        accepted++;
      end else begin
        bus.a_bit = 1'($urandom_range(0, 1));
        bus.b_bit = 1'($urandom_range(0, 1));
      end
      stepCycle();
      bus.start     = 1'b0;
      bus.bit_valid = 1'b0;
      if (accepted < WIDTH) begin
        checkOutput("busy_mid_word", bus.busy, 1);
        checkOutput("done_mid_word", bus.done, 0);
        checkOutput("equal_held", bus.equal, exp_equal);
        checkOutput("count_held", bus.match_count, exp_count);
      end
    end

    modelWord(a, b);
    checkOutput("done_pulse", bus.done, 1);
    checkOutput("busy_at_done", bus.busy, 0);
    checkResults("word");

    bus.start     = poke_start;
    bus.bit_valid = 1'($urandom_range(0, 1));
    stepCycle();
    bus.start     = 1'b0;
    bus.bit_valid = 1'b0;
    checkOutput("done_cleared", bus.done, 0);
    checkOutput("busy_after_done", bus.busy, 0);
    checkResults("hold");
  endtask

  initial begin
    logic [WIDTH-1:0] ra;
    logic [WIDTH-1:0] rb;

    rst           = 1'b1;
    bus.start     = 1'b0;
    bus.bit_valid = 1'b0;
    bus.a_bit     = 1'b0;
    bus.b_bit     = 1'b0;
    #12;
    checkOutput("reset_busy", bus.busy, 0);
    checkOutput("reset_done", bus.done, 0);
    checkResults("reset");
    rst = 1'b0;
    stepCycle();

    $display("[TB] directed words");
    applyStimulus(4'b1010, 4'b1010, 0, 1'b0);
    applyStimulus(4'b1011, 4'b1001, 0, 1'b0);
    applyStimulus(4'b0000, 4'b1111, 0, 1'b0);

    $display("[TB] stall pattern");
    applyStimulus(4'b0110, 4'b0110, 1, 1'b0);

    $display("[TB] ignored starts");
    applyStimulus(4'b1100, 4'b0100, 0, 1'b1);

    $display("[TB] bit_valid while idle");
    for (int i = 0; i < 3; i++) begin
      bus.bit_valid = 1'b1;
      bus.a_bit     = 1'($urandom_range(0, 1));
      bus.b_bit     = ~bus.a_bit;
      stepCycle();
      checkOutput("idle_busy", bus.busy, 0);
      checkOutput("idle_done", bus.done, 0);
      checkResults("idle");
    end
    bus.bit_valid = 1'b0;

    $display("[TB] reset mid-word");
    bus.start = 1'b1;
    stepCycle();
    bus.start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      bus.bit_valid = 1'b1;
      bus.a_bit     = 1'b1;
      bus.b_bit     = 1'b0;
      stepCycle();
    end
    bus.bit_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    exp_equal = 0;
    exp_count = 0;
    exp_seen  = 0;
    exp_first = 0;
    checkOutput("async_rst_busy", bus.busy, 0);
    checkOutput("async_rst_done", bus.done, 0);
    checkResults("async_rst");
    #3;
    rst = 1'b0;
    stepCycle();
    applyStimulus(4'b0111, 4'b0011, 0, 1'b0);

    $display("[TB] back-to-back words");
    applyStimulus(4'b0101, 4'b0101, 0, 1'b0);
    applyStimulus(4'b1000, 4'b0000, 0, 1'b0);

    $display("[TB] random words");
    for (int n = 0; n < 24; n++) begin
      ra = WIDTH'($urandom);
      rb = ($urandom_range(0, 3) == 0) ? ra : WIDTH'($urandom);
      applyStimulus(ra, rb, 2, 1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
